// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: function classes and per-class opcodes.
package alu_pkg;

  localparam logic [1:0] FC_SHIFT = 2'b00;
  localparam logic [1:0] FC_SLT   = 2'b01;
  localparam logic [1:0] FC_ARITH = 2'b10;
  localparam logic [1:0] FC_LOGIC = 2'b11;

  localparam logic [1:0] AND = 2'b00;
  localparam logic [1:0] OR  = 2'b01;
  localparam logic [1:0] XOR = 2'b10;
  localparam logic [1:0] NOR = 2'b11;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] SLL  = 2'b01;
  localparam logic [1:0] SRL  = 2'b10;
  localparam logic [1:0] SRA  = 2'b11;

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder/subtractor: sum, carry out of the top bit, and signed overflow.
module alu_addsub #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o,
  output logic         ovf_o
);

  logic [N-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  // Subtract uses the carry-in to complete the two's complement of b.
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, sub_i};
  assign ovf_o = (a_i[N-1] == b_eff[N-1]) && (sum_o[N-1] != a_i[N-1]);

endmodule

// File: rtl/alu_core.sv
// Registered N-bit ALU: shift, set-less-than, arithmetic and logic classes with
// zero/overflow/carry flags, one cycle of latency.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   opcode,
  input  logic [1:0]   fnClass,
  output logic [N-1:0] out,
  output logic         zerof,
  output logic         ovf,
  output logic         c_out
);

  localparam int unsigned ShW = $clog2(N);

  logic [ShW-1:0] sh;
  logic [N-1:0]   sum;
  logic           carry;
  logic           as_ovf;
  logic           as_sub;
  logic           slt_lt;
  logic [N-1:0]   sra_res;

  logic [N-1:0] out_d, out_q;
  logic         zerof_d, zerof_q;
  logic         ovf_d, ovf_q;
  logic         c_out_d, c_out_q;

  assign sh = b[ShW-1:0];

  // Compare reuses the subtractor, so SLT always subtracts.
  assign as_sub = (fnClass == FC_SLT) || opcode[1];

  alu_addsub #(
    .N (N)
  ) u_addsub (
    .a_i     (a),
    .b_i     (b),
    .sub_i   (as_sub),
    .sum_o   (sum),
    .carry_o (carry),
    .ovf_o   (as_ovf)
  );

  assign slt_lt  = opcode[0] ? ~carry : (sum[N-1] ^ as_ovf);
  assign sra_res = $signed(a) >>> sh;

  always_comb begin
    out_d   = '0;
    ovf_d   = 1'b0;
    c_out_d = 1'b0;
    unique case (fnClass)
      FC_SHIFT: begin
        unique case (opcode)
          NONE:    out_d = a;
          SLL:     out_d = a << sh;
          SRL:     out_d = a >> sh;
          SRA:     out_d = sra_res;
          default: out_d = a;
        endcase
      end
      FC_SLT: out_d = {{(N-1){1'b0}}, slt_lt};
      FC_ARITH: begin
        out_d   = sum;
        ovf_d   = as_ovf;
        c_out_d = carry;
      end
      FC_LOGIC: begin
        unique case (opcode)
          AND:     out_d = a & b;
          OR:      out_d = a | b;
          XOR:     out_d = a ^ b;
          NOR:     out_d = ~(a | b);
          default: out_d = a & b;
        endcase
      end
      default: out_d = '0;
    endcase
    zerof_d = (out_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      zerof_q <= 1'b0;
      ovf_q   <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      zerof_q <= zerof_d;
      ovf_q   <= ovf_d;
      c_out_q <= c_out_d;
    end
  end

  assign out   = out_q;
  assign zerof = zerof_q;
  assign ovf   = ovf_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vector table, reset sequences, and random ops
// checked against an arithmetic reference model.
module tb_alu_core;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  opcode;
  logic [1:0]  fnClass;
  logic [31:0] out;
  logic        zerof;
  logic        ovf;
  logic        c_out;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  fc;
    logic [1:0]  op;
    logic [31:0] e_out;
    logic        e_z;
    logic        e_v;
    logic        e_c;
  } vec_t;

  vec_t tbl[$];

  alu_core #(
    .N (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .opcode  (opcode),
    .fnClass (fnClass),
    .out     (out),
    .zerof   (zerof),
    .ovf     (ovf),
    .c_out   (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] e_out, input logic e_z,
                       input logic e_v, input logic e_c);
    checks++;
    if ({out, zerof, ovf, c_out} !== {e_out, e_z, e_v, e_c}) begin
      failures++;
      $display("FAIL %s: got out=%h z=%b v=%b c=%b, expected out=%h z=%b v=%b c=%b",
               name, out, zerof, ovf, c_out, e_out, e_z, e_v, e_c);
    end
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] tfc,
                       input logic [1:0] top);
    @(negedge clk);
    a       = ta;
    b       = tb;
    fnClass = tfc;
    opcode  = top;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [1:0] fc, input logic [1:0] op);
    logic [31:0] r;
    logic        v;
    logic        c;
    longint      sa;
    longint      sb;
    longint      ss;
    longint      us;
    int          sh;
    r  = 32'h0;
    v  = 1'b0;
    c  = 1'b0;
    sa = $signed(ma);
    sb = $signed(mb);
    sh = int'(mb % 32);
    case (fc)
      2'b00: begin
        case (op)
          2'b00: r = ma;
          2'b01: r = ma << sh;
          2'b10: r = ma >> sh;
          default: r = (ma >> sh) | (ma[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        endcase
      end
      2'b01: begin
        if (op[0]) r = (ma < mb) ? 32'd1 : 32'd0;
        else       r = (sa < sb) ? 32'd1 : 32'd0;
      end
      2'b10: begin
        if (!op[1]) begin
          us = longint'(ma) + longint'(mb);
          r  = us[31:0];
          c  = us[32];
          ss = sa + sb;
        end else begin
          r  = ma - mb;
          c  = (ma >= mb);
          ss = sa - sb;
        end
        v = (ss > MaxS) || (ss < MinS);
      end
      default: begin
        case (op)
          2'b00: r = ma & mb;
          2'b01: r = ma | mb;
          2'b10: r = ma ^ mb;
          default: r = ~(ma | mb);
        endcase
      end
    endcase
    return {r, (r == 32'h0), v, c};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp[6];
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'h7FFF_FFFF;
    sp[3] = 32'h8000_0000;
    sp[4] = 32'hFFFF_FFFF;
    sp[5] = 32'h0000_001F;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] va, input logic [31:0] vb,
                              input logic [1:0] fc, input logic [1:0] op,
                              input logic [31:0] eo, input logic ez, input logic ev,
                              input logic ec);
    vec_t t;
    t.name = n; t.a = va; t.b = vb; t.fc = fc; t.op = op;
    t.e_out = eo; t.e_z = ez; t.e_v = ev; t.e_c = ec;
    return t;
  endfunction

  initial begin
    logic [34:0] exp;
    checks   = 0;
    failures = 0;

    tbl.push_back(mk("add_3_2",      32'h3,         32'h2, 2'b10, 2'b00, 32'h5,         0, 0, 0));
    tbl.push_back(mk("sub_5_2",      32'h5,         32'h2, 2'b10, 2'b11, 32'h3,         0, 0, 1));
    tbl.push_back(mk("sub_7_7",      32'h7,         32'h7, 2'b10, 2'b11, 32'h0,         1, 0, 1));
    tbl.push_back(mk("and_5_3",      32'h5,         32'h3, 2'b11, 2'b00, 32'h1,         0, 0, 0));
    tbl.push_back(mk("sll_5_3",      32'h5,         32'h3, 2'b00, 2'b01, 32'h28,        0, 0, 0));
    tbl.push_back(mk("add_ovf",      32'h7FFF_FFFF, 32'h1, 2'b10, 2'b00, 32'h8000_0000, 0, 1, 0));
    tbl.push_back(mk("add_carry",    32'hFFFF_FFFF, 32'h1, 2'b10, 2'b00, 32'h0,         1, 0, 1));
    tbl.push_back(mk("slt_signed",   32'hFFFF_FFFF, 32'h1, 2'b01, 2'b00, 32'h1,         0, 0, 0));
    tbl.push_back(mk("slt_unsigned", 32'hFFFF_FFFF, 32'h1, 2'b01, 2'b01, 32'h0,         1, 0, 0));
    tbl.push_back(mk("sra_neg",      32'h8000_0000, 32'h4, 2'b00, 2'b11, 32'hF800_0000, 0, 0, 0));
    tbl.push_back(mk("srl_sh0",      32'h1234_5678, 32'h20, 2'b00, 2'b10, 32'h1234_5678, 0, 0, 0));
    tbl.push_back(mk("nor_0_0",      32'h0,         32'h0, 2'b11, 2'b11, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk("xor",          32'hA5A5_A5A5, 32'hFFFF_0000, 2'b11, 2'b10, 32'h5A5A_A5A5, 0, 0, 0));
    tbl.push_back(mk("or_zero",      32'h0,         32'h0, 2'b11, 2'b01, 32'h0,         1, 0, 0));
    tbl.push_back(mk("sub_borrow",   32'h0,         32'h1, 2'b10, 2'b10, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk("sub_ovf",      32'h8000_0000, 32'h1, 2'b10, 2'b11, 32'h7FFF_FFFF, 0, 1, 1));
    tbl.push_back(mk("slt_op1_ign",  32'h8000_0000, 32'h0, 2'b01, 2'b10, 32'h1,         0, 0, 0));
    tbl.push_back(mk("add_op0_ign",  32'h1,         32'h1, 2'b10, 2'b01, 32'h2,         0, 0, 0));

    a = 32'h3; b = 32'h2; fnClass = 2'b10; opcode = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].fc, tbl[i].op);
      check(tbl[i].name, tbl[i].e_out, tbl[i].e_z, tbl[i].e_v, tbl[i].e_c);
    end

    // Mid-cycle asynchronous reset, then live result on the first edge after release.
    drive(32'h3, 32'h2, 2'b10, 2'b00);
    check("pre_reset_add", 32'h5, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h7FFF_FFFF; b = 32'h1; fnClass = 2'b10; opcode = 2'b00;
    @(posedge clk);
    #1;
    check("post_reset_live", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rfc;
      logic [1:0]  rop;
      ra  = pick();
      rb  = pick();
      rfc = 2'($urandom_range(0, 3));
      rop = 2'($urandom_range(0, 3));
      exp = model(ra, rb, rfc, rop);
      drive(ra, rb, rfc, rop);
      check($sformatf("rand%0d fc=%b op=%b a=%h b=%h", i, rfc, rop, ra, rb),
            exp[34:3], exp[2], exp[1], exp[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- N-bit registered ALU: four function classes (shift, set-less-than, arithmetic, logic), each selected by a 2-bit opcode.
- Produces a result plus zero, signed-overflow and carry flags.
- Sits in the execute stage of the datapath; all outputs are registered, giving a 1-cycle latency.

Parameters:
- N, 32, operand/result width in bits (N >= 2, power of two).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  N  operand A (shifted operand for shift class)
- b  input  N  operand B (shift amount taken from b[$clog2(N)-1:0] for shift class)
- opcode  input  2  operation within class
- fnClass  input  2  function class: 00 shift, 01 set-less-than, 10 arithmetic, 11 logic
- out  output  N  registered result
- zerof  output  1  registered: out == 0
- ovf  output  1  registered signed overflow (arithmetic class only)
- c_out  output  1  registered adder carry-out (arithmetic class only)

Behaviour:
- Reset (rst_n low, async): out = 0, zerof = 0, ovf = 0, c_out = 0, held while rst_n is low.
- Release of reset is sampled synchronously; the first result appears on the first clk rise after release.
- Latency: inputs sampled on clk rise edge k; out and flags valid after edge k, until edge k+1. No handshake; a new operation is accepted every cycle.
- Shift class (fnClass 00); sh = b[$clog2(N)-1:0]:
  - opcode 00: out = a (no shift)
  - 01: a << sh (logical left, zero fill)
  - 10: a >> sh (logical right, zero fill)
  - 11: arithmetic right (sign fill)
  - sh = 0 yields a for every opcode.
- Set-less-than class (fnClass 01):
  - opcode[0] = 0: signed compare
  - opcode[0] = 1: unsigned compare
  - out = {N-1 zeros, (a < b)}; opcode[1] ignored.
- Arithmetic class (fnClass 10): opcode[1] = 0 -> add, out = a + b; opcode[1] = 1 -> subtract, out = a + ~b + 1. opcode[0] ignored (00/01 add, 10/11 subtract).
  - c_out = carry out of bit N-1 of the N-bit adder. For subtract, 1 means no borrow (a >= b unsigned).
  - ovf = 1 when both adder inputs (a and b, or a and ~b) share a sign and the result sign differs.
  - Result wraps modulo 2^N.
- Logic class (fnClass 11): 00 AND, 01 OR, 10 XOR, 11 NOR.
- Flags:
  - zerof = (next out == 0), computed for every class.
  - ovf and c_out are forced to 0 for all non-arithmetic classes.
- All inputs are combinationally decoded; no X propagation on legal codes. Every encoding is legal; there are no reserved codes.
- Reset asserted mid-stream clears the outputs immediately, regardless of clk.

Decomposition:
- Shared package alu_pkg holds:
  - function-class constants: FC_SHIFT = 2'b00, FC_SLT = 2'b01, FC_ARITH = 2'b10, FC_LOGIC = 2'b11
  - logic opcode constants: AND, OR, XOR, NOR
  - shift opcode constants: NONE, SLL, SRL, SRA
- One natural sub-module, alu_addsub: N-bit adder/subtractor producing sum, carry and overflow. It is also reused for the set-less-than compare (signed less-than = sum sign XOR ovf; unsigned less-than = ~carry).
- Shift, logic, and result/flag registers stay in alu_core.

Test Plan:
- Add: a = 0x00000003, b = 0x00000002, fnClass = 10, opcode = 00 -> after 1 clk: out = 0x00000005, zerof = 0, ovf = 0, c_out = 0.
- Subtract: a = 5, b = 2, fnClass = 10, opcode = 11 -> out = 0x00000003, c_out = 1, ovf = 0, zerof = 0. Then a = b = 7 -> out = 0, zerof = 1, c_out = 1.
- Logic then shift: a = 5, b = 3, fnClass = 11, opcode = 00 -> out = 0x00000001. Then fnClass = 00, opcode = 01 -> out = 0x00000028, ovf = 0, c_out = 0.
- Overflow/carry: 0x7FFFFFFF + 1 -> out = 0x80000000, ovf = 1, c_out = 0. Then 0xFFFFFFFF + 1 -> out = 0, zerof = 1, c_out = 1, ovf = 0.
- Compare and arithmetic shift:
  - SLT signed, a = 0xFFFFFFFF, b = 1 -> out = 1.
  - SLT unsigned, same operands -> out = 0.
  - SRA, a = 0x80000000, b = 4 -> out = 0xF8000000.
- Reset: drive a valid add, then assert rst_n = 0 between clock edges -> out and all flags 0 immediately. After release, next clk edge shows the live result.
